nebula_node_sink: RTL

Endpoint receiver for one mesh node. It attaches to a `nebula_router` local response port (`local_resp_*`) and consumes the flits the router delivers there. Each flit is buffered in a small FIFO, checked for correct destination and per-source sequence order, and counted into saturating statistics registers. It is the receive-side counterpart of the node packet injector and serves as the synthesizable delivery checker for full-mesh system runs.

---
 rtl/nebula_node_sink.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/nebula_node_sink.sv
// -----------------------------------------------------------------------------
// nebula_pkg / nebula_node_sink
//
// Purpose:
//   Endpoint receiver for one mesh node. It sits on a nebula_router local
//   response port, buffers each delivered flit in a small FIFO, checks that the
//   flit was addressed to this node and that DATA flits from each source arrive
//   in sequence order, and keeps saturating statistics.
//
// Optional feature macro:
//   NEBULA_SINK_LATENCY_EN - builds a free-running 32-bit cycle counter and
//                            tracks worst-case latency (now - data[31:0]) of
//                            correctly routed DATA flits in max_latency.
//                            Undefined: max_latency is constant 0.
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   resp_data      in   flit_t from the router local port
//   resp_valid     in   flit valid
//   resp_ready     out  sink can accept a flit (registered state only)
//   sink_stall     in   inhibit popping the FIFO (slow consumer model)
//   stats_clr      in   pulse: clear statistics, flush FIFO, re-run table init
//   init_done      out  high while in RUN
//   rx_count       out  flits popped and checked (32-bit, saturating)
//   misroute_count out  flits not addressed to this node (16-bit, saturating)
//   seq_err_count  out  per-source sequence mismatches (16-bit, saturating)
//   err_flag       out  sticky error indication
//   max_latency    out  worst observed latency, 0 unless the feature is built
// -----------------------------------------------------------------------------

package nebula_pkg;

    localparam int COORD_W = 4;

    typedef enum logic [1:0] {
        PACKET_DATA  = 2'd0,
        PACKET_READ  = 2'd1,
        PACKET_WRITE = 2'd2,
        PACKET_RESP  = 2'd3
    } packet_type_t;

    typedef struct packed {
        logic [COORD_W-1:0] dest_x;
        logic [COORD_W-1:0] dest_y;
        logic [COORD_W-1:0] src_x;
        logic [COORD_W-1:0] src_y;
        packet_type_t       packet_type;
        logic [15:0]        sequence_num;
        logic [63:0]        data;
    } flit_t;

endpackage

module nebula_node_sink
    import nebula_pkg::*;
#(
    parameter int MY_X_COORD  = 0,
    parameter int MY_Y_COORD  = 0,
    parameter int MESH_SIZE_X = 8,
    parameter int MESH_SIZE_Y = 8,
    parameter int NUM_SRC     = MESH_SIZE_X * MESH_SIZE_Y,
    parameter int FIFO_DEPTH  = 4,
    parameter int SEQ_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  flit_t       resp_data,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic        sink_stall,
    input  logic        stats_clr,
    output logic        init_done,
    output logic [31:0] rx_count,
    output logic [15:0] misroute_count,
    output logic [15:0] seq_err_count,
    output logic        err_flag,
    output logic [15:0] max_latency
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Saturation helpers
    // -------------------------------------------------------------------------
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (|v[31:16]) ? 16'hFFFF : v[15:0];
    endfunction

    // -------------------------------------------------------------------------
    // FSM: INIT sweeps the expected-sequence table to zero, RUN checks flits
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (stats_clr) begin
            state_d = ST_INIT;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (idx_q == IDX_W'(NUM_SRC - 1)) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign init_done = (state_q == ST_RUN);

    // -------------------------------------------------------------------------
    // Input FIFO
    // -------------------------------------------------------------------------
    flit_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push, pop;
    flit_t             head;

    // Ready looks only at registered state, so a full FIFO keeps it low even
    // in a cycle that pops; this keeps resp_valid -> resp_ready path-free.
    assign resp_ready = (state_q == ST_RUN) && (count_q < CNT_W'(FIFO_DEPTH));
    assign push       = resp_valid && resp_ready;
    assign pop        = (state_q == ST_RUN) && (count_q != '0) && !sink_stall;
    assign head       = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage is data only; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= resp_data;
    end

    // -------------------------------------------------------------------------
    // Head-flit classification
    // -------------------------------------------------------------------------
    logic              dest_ok, is_data, src_ok, seq_chk, seq_bad;
    int                src_lin;
    logic [IDX_W-1:0]  src_idx;
    logic [SEQ_W-1:0]  seq_got;
    logic [SEQ_W-1:0]  exp_q [NUM_SRC];

    always_comb begin
        dest_ok = (head.dest_x == COORD_W'(MY_X_COORD)) &&
                  (head.dest_y == COORD_W'(MY_Y_COORD));
        is_data = (head.packet_type == PACKET_DATA);
        src_lin = int'(head.src_y) * MESH_SIZE_X + int'(head.src_x);
        // A source outside the table cannot be tracked; it is counted but not
        // sequence-checked.
        src_ok  = (src_lin < NUM_SRC);
        src_idx = IDX_W'(src_lin);
        seq_got = head.sequence_num[SEQ_W-1:0];
        seq_chk = pop && dest_ok && is_data && src_ok;
        seq_bad = seq_chk && (seq_got != exp_q[src_idx]);
    end

    // -------------------------------------------------------------------------
    // Expected-sequence table: zeroed during INIT, resynced on every check
    // -------------------------------------------------------------------------
    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_widx;
    logic [SEQ_W-1:0]  tbl_wdata;

    always_comb begin
        tbl_we    = 1'b0;
        tbl_widx  = src_idx;
        tbl_wdata = seq_got + SEQ_W'(1);
        if (!rst) begin
            if (state_q == ST_INIT) begin
                tbl_we    = 1'b1;
                tbl_widx  = idx_q;
                tbl_wdata = '0;
            end else if (seq_chk) begin
                tbl_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) exp_q[tbl_widx] <= tbl_wdata;
    end

    // -------------------------------------------------------------------------
    // Statistics
    // -------------------------------------------------------------------------
    logic [31:0] rx_q, rx_d;
    logic [15:0] mis_q, mis_d;
    logic [15:0] seqerr_q, seqerr_d;
    logic        err_q, err_d;

    always_comb begin
        rx_d     = rx_q;
        mis_d    = mis_q;
        seqerr_d = seqerr_q;
        err_d    = err_q;
        if (pop) begin
            rx_d = sat_inc32(rx_q);
            if (!dest_ok) begin
                mis_d = sat_inc16(mis_q);
                err_d = 1'b1;
            end
        end
        if (seq_bad) begin
            seqerr_d = sat_inc16(seqerr_q);
            err_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            rx_q     <= '0;
            mis_q    <= '0;
            seqerr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rx_q     <= rx_d;
            mis_q    <= mis_d;
            seqerr_q <= seqerr_d;
            err_q    <= err_d;
        end
    end

    assign rx_count       = rx_q;
    assign misroute_count = mis_q;
    assign seq_err_count  = seqerr_q;
    assign err_flag       = err_q;

    // -------------------------------------------------------------------------
    // Optional latency tracking
    // -------------------------------------------------------------------------
`ifdef NEBULA_SINK_LATENCY_EN
    logic [31:0] now_q;
    logic [31:0] lat;
    logic [15:0] max_lat_q, max_lat_d;

    // Cycle counter only restarts on rst so timestamps stay comparable across
    // a stats_clr.
    always_ff @(posedge clk) begin
        if (rst) now_q <= '0;
        else     now_q <= now_q + 32'd1;
    end

    always_comb begin
        lat       = now_q - head.data[31:0];
        max_lat_d = max_lat_q;
        if (pop && dest_ok && is_data && (sat16(lat) > max_lat_q)) begin
            max_lat_d = sat16(lat);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stats_clr) max_lat_q <= '0;
        else                  max_lat_q <= max_lat_d;
    end

    assign max_latency = max_lat_q;
`else
    assign max_latency = '0;
`endif

    // Flit fields not consumed in every configuration.
    logic unused_bits;
    assign unused_bits = ^{head.data, head.sequence_num};

endmodule
